// File: rtl/binary_divider.sv
// Multi-cycle unsigned 64/64 restoring divider with a saturating 32-bit quotient.
// One quotient bit per clock; start on div_en while idle, one-cycle done pulse on completion.
module binary_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_en,
    input  logic [63:0] g_dividend_Q,
    input  logic [63:0] g_divider_Q,
    output logic [31:0] quotient,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e      state_q;
    logic        rdy_q;
    logic [5:0]  cnt_q;
    logic [63:0] rem_q;
    logic [63:0] dvd_q;
    logic [63:0] dvs_q;
    logic [63:0] wq_q;
    logic [31:0] quot_q;
    logic        done_q;

    logic [64:0] rem_sh;
    logic        ge;
    logic [63:0] rem_d;
    logic [63:0] wq_d;

    // The shifted remainder is 65 bits wide; after a successful subtract the
    // result is below the divisor, so 64 stored bits always suffice.
    always_comb begin
        rem_sh = {rem_q, dvd_q[63]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_d  = ge ? (rem_sh[63:0] - dvs_q) : rem_sh[63:0];
        wq_d   = {wq_q[62:0], ge};
    end

    // Reset release is registered once, so the first start is taken on the
    // second rising edge after deassertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            wq_q    <= '0;
            quot_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_en && rdy_q) begin
                        dvd_q   <= g_dividend_Q;
                        dvs_q   <= g_divider_Q;
                        rem_q   <= '0;
                        wq_q    <= '0;
                        cnt_q   <= 6'd63;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[62:0], 1'b0};
                    wq_q  <= wq_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) state_q <= FINISH;
                end
                FINISH: begin
                    if (dvs_q == 64'd0 || wq_q[63:32] != 32'd0) quot_q <= 32'hFFFF_FFFF;
                    else                                        quot_q <= wq_q[31:0];
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient = quot_q;
    assign done     = done_q;

endmodule

// File: tb/tb_binary_divider.sv
// Self-checking bench for binary_divider: directed cases from the test plan
// plus randomized operands against a plain-arithmetic reference.
module tb_binary_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_en;
    logic [63:0] g_dividend_Q;
    logic [63:0] g_divider_Q;
    logic [31:0] quotient;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    binary_divider dut (
        .clk          (clk),
        .reset        (reset),
        .div_en       (div_en),
        .g_dividend_Q (g_dividend_Q),
        .g_divider_Q  (g_divider_Q),
        .quotient     (quotient),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q;
        if (b == 64'd0) return 32'hFFFF_FFFF;
        q = a / b;
        if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return q[31:0];
    endfunction

    // Called just after a start edge; returns cycles until done (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input logic [63:0] a, input logic [63:0] b, output int lat);
        @(negedge clk);
        g_dividend_Q = a;
        g_divider_Q  = b;
        div_en       = 1'b1;
        @(posedge clk); #1;
        div_en       = 1'b0;
        g_dividend_Q = {$urandom, $urandom};
        g_divider_Q  = {$urandom, $urandom};
        wait_done(lat);
    endtask

    // Full check of one division: latency, result, done falls, result holds.
    task automatic check_div(input string tag, input logic [63:0] a, input logic [63:0] b);
        int          lat;
        logic [31:0] exp;
        exp = ref_q(a, b);
        run_div(a, b, lat);
        chk({tag, " latency"}, 64'(lat), 64'd65);
        chk({tag, " quotient"}, {32'd0, quotient}, {32'd0, exp});
        @(posedge clk); #1;
        chk({tag, " done low"}, {63'd0, done}, 64'd0);
        chk({tag, " hold"}, {32'd0, quotient}, {32'd0, exp});
    endtask

    initial begin
        int          lat;
        int          ndone;
        int          first;
        logic [63:0] a;
        logic [63:0] b;

        reset        = 1'b0;
        div_en       = 1'b0;
        g_dividend_Q = 64'd765;
        g_divider_Q  = 64'd63;
        repeat (3) @(posedge clk);
        #1;
        chk("reset quotient", {32'd0, quotient}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);

        // div_en high from release: edge 1 must not start, edge 2 must.
        @(negedge clk);
        reset  = 1'b1;
        div_en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        div_en = 1'b0;
        wait_done(lat);
        chk("first start latency", 64'(lat), 64'd65);
        chk("765/63", {32'd0, quotient}, 64'd12);
        @(posedge clk); #1;
        chk("765/63 done low", {63'd0, done}, 64'd0);
        chk("765/63 hold", {32'd0, quotient}, 64'd12);

        check_div("63/765", 64'd63, 64'd765);
        check_div("2^40/1", 64'h100_0000_0000, 64'd1);
        check_div("ffffffff/1", 64'h0000_0000_FFFF_FFFF, 64'd1);
        check_div("1000/0", 64'd1000, 64'd0);
        check_div("max/max", '1, '1);

        // Strobe during BUSY with new operands must be dropped.
        @(negedge clk);
        g_dividend_Q = 64'd765;
        g_divider_Q  = 64'd63;
        div_en       = 1'b1;
        @(posedge clk); #1;
        div_en = 1'b0;
        ndone  = 0;
        first  = -1;
        for (int k = 1; k <= 80; k++) begin
            if (k == 10) begin
                g_dividend_Q = 64'd100;
                g_divider_Q  = 64'd10;
                div_en       = 1'b1;
            end
            if (k == 11) div_en = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        chk("busy strobe done cycle", 64'(first), 64'd65);
        chk("busy strobe done count", 64'(ndone), 64'd1);
        chk("busy strobe quotient", {32'd0, quotient}, 64'd12);

        // div_en held high: back-to-back divisions every 66 cycles.
        @(negedge clk);
        g_dividend_Q = 64'd5000;
        g_divider_Q  = 64'd7;
        div_en       = 1'b1;
        @(posedge clk); #1;
        wait_done(lat);
        chk("continuous first", 64'(lat), 64'd65);
        chk("continuous q1", {32'd0, quotient}, 64'd714);
        g_dividend_Q = 64'd81;
        g_divider_Q  = 64'd9;
        wait_done(lat);
        div_en = 1'b0;
        chk("continuous period", 64'(lat), 64'd66);
        chk("continuous q2", {32'd0, quotient}, 64'd9);
        @(posedge clk); #1;
        chk("continuous done low", {63'd0, done}, 64'd0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        g_dividend_Q = 64'd765;
        g_divider_Q  = 64'd63;
        div_en       = 1'b1;
        @(posedge clk); #1;
        div_en = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async reset quotient", {32'd0, quotient}, 64'd0);
        chk("async reset done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        chk("abort quotient", {32'd0, quotient}, 64'd0);
        check_div("after reset 765/63", 64'd765, 64'd63);

        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 63);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i % 8 == 3) b = 64'd0;
            if (i % 8 == 5) b = a >> $urandom_range(1, 31);
            check_div($sformatf("rand%0d", i), a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
